// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter for the Sobel display path.
// Buffers the processed pixel stream in a small FIFO and shares one
// single-port picture RAM between that writer and the VGA reader. The reader
// has fixed priority; writes fill the RAM sequentially and wrap every frame.
//
// Ports
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   pi_data, pi_flag        incoming pixel and its single-cycle valid strobe
//   rd_req, rd_addr         display read request and address
//   rd_data, rd_valid       returned pixel, valid two cycles after the grant
//   ram_addr, ram_wr_en,    RAM address and strobes (registered, never both
//   ram_rd_en, ram_wdata    strobes high at once), RAM write data
//   ram_rdata               RAM read data, valid one cycle after ram_rd_en
//   frame_done              pulse with the write to the last frame address
//   pic_ready               set once a full frame has been written
//   ovf                     sticky: a pixel was dropped on a full FIFO
module fb_arbiter #(
  parameter int PIC_SIZE   = 9604,
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        pi_data,
  input  logic              pi_flag,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              frame_done,
  output logic              pic_ready,
  output logic              ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_SIZE - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              rd_pend_q;
  logic              fifo_empty, fifo_full, push, pop;

  // Grant decision and FIFO bookkeeping for the coming edge. The grant only
  // looks at the registered FIFO count, so a pixel pushed this cycle is
  // written no earlier than the next one.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    if (rd_req) begin
      state_d = READ;
    end else if (!fifo_empty) begin
      state_d = WRITE;
    end else begin
      state_d = IDLE;
    end
    pop   = (state_d == WRITE);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push  = pi_flag && (!fifo_full || pop);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
  end

  // FIFO storage carries data only; occupancy lives in the control registers.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wptr_q] <= pi_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_addr_q  <= '0;
      rd_pend_q  <= 1'b0;
      ram_addr   <= '0;
      ram_wr_en  <= 1'b0;
      ram_rd_en  <= 1'b0;
      ram_wdata  <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      frame_done <= 1'b0;
      pic_ready  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_wr_en  <= 1'b0;
      ram_rd_en  <= 1'b0;
      frame_done <= 1'b0;

      // Read return: grant visible on the RAM port now, RAM answers next
      // cycle, and the answer is registered the cycle after that.
      rd_pend_q <= (state_q == READ);
      rd_valid  <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data <= ram_rdata;
      end

      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pi_flag && !push) begin
        ovf <= 1'b1;
      end

      case (state_d)
        READ: begin
          ram_addr  <= rd_addr;
          ram_rd_en <= 1'b1;
        end
        WRITE: begin
          ram_addr  <= wr_addr_q;
          ram_wdata <= fifo_mem[rptr_q];
          ram_wr_en <= 1'b1;
          rptr_q    <= rptr_q + PTR_W'(1);
          wr_addr_q <= wr_addr_d;
          if (wr_addr_q == LAST_ADDR) begin
            frame_done <= 1'b1;
            pic_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: RAM model, queue-based reference model compared on
// every cycle, directed scenarios with hand-computed expectations, and a
// randomized traffic phase.
module tb_fb_arbiter;

  localparam int PIC_SIZE   = 9604;
  localparam int ADDR_W     = 14;
  localparam int FIFO_DEPTH = 4;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [7:0]        pi_data   = '0;
  logic              pi_flag   = 1'b0;
  logic              rd_req    = 1'b0;
  logic [ADDR_W-1:0] rd_addr   = '0;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              frame_done;
  logic              pic_ready;
  logic              ovf;

  fb_arbiter #(.PIC_SIZE(PIC_SIZE), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_data(pi_data), .pi_flag(pi_flag),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .frame_done(frame_done), .pic_ready(pic_ready), .ovf(ovf)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Single-port RAM model driven by the DUT
  logic [7:0] ram [16384];
  always @(posedge sys_clk) begin
    if (ram_wr_en === 1'b1) ram[ram_addr] <= ram_wdata;
    if (ram_rd_en === 1'b1) ram_rdata <= ram[ram_addr];
  end

  // Reference model: FIFO as a queue, RAM contents as an array,
  // read returns as a two-deep delay of (valid, value).
  logic [7:0]        m_mem [16384];
  logic [7:0]        m_q [$];
  int                m_wa;
  logic [ADDR_W-1:0] m_addr;
  logic              m_wr, m_rd, m_rvalid, m_fd, m_ready, m_ovf;
  logic [7:0]        m_wdata, m_rdata;
  logic              r0_v, r1_v;
  logic [7:0]        r0_d, r1_d;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_q.delete();
      m_wa = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_wr = 0; m_rd = 0; m_rvalid = 0; m_fd = 0; m_ready = 0; m_ovf = 0;
      r0_v = 0; r1_v = 0; r0_d = '0; r1_d = '0;
    end else begin
      m_wr = 0; m_rd = 0; m_fd = 0;
      m_rvalid = r1_v;
      if (r1_v) m_rdata = r1_d;
      r1_v = r0_v; r1_d = r0_d; r0_v = 0;
      if (rd_req) begin
        m_rd = 1; m_addr = rd_addr;
        r0_v = 1; r0_d = m_mem[rd_addr];
      end else if (m_q.size() > 0) begin
        m_wr = 1; m_addr = ADDR_W'(m_wa);
        m_wdata = m_q.pop_front();
        m_mem[m_wa] = m_wdata;
        if (m_wa == PIC_SIZE - 1) begin m_fd = 1; m_ready = 1; end
        m_wa = (m_wa + 1) % PIC_SIZE;
      end
      if (pi_flag) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(pi_data);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  bit cmp_en = 0;
  always @(negedge sys_clk) begin
    if (cmp_en) begin
      chk("ram_addr",   32'(ram_addr),   32'(m_addr));
      chk("ram_wr_en",  32'(ram_wr_en),  32'(m_wr));
      chk("ram_rd_en",  32'(ram_rd_en),  32'(m_rd));
      chk("ram_wdata",  32'(ram_wdata),  32'(m_wdata));
      chk("rd_valid",   32'(rd_valid),   32'(m_rvalid));
      chk("rd_data",    32'(rd_data),    32'(m_rdata));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("pic_ready",  32'(pic_ready),  32'(m_ready));
      chk("ovf",        32'(ovf),        32'(m_ovf));
    end
  end

  // Event log of RAM grants, read returns and frame pulses
  byte ev_k [$];
  int  ev_a [$];
  int  ev_d [$];
  int  n_rv = 0, n_fd = 0, fd_addr = -1;
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (ram_wr_en === 1'b1) begin ev_k.push_back("W"); ev_a.push_back(int'(ram_addr)); ev_d.push_back(int'(ram_wdata)); end
      if (ram_rd_en === 1'b1) begin ev_k.push_back("R"); ev_a.push_back(int'(ram_addr)); ev_d.push_back(0); end
      if (rd_valid === 1'b1) n_rv++;
      if (frame_done === 1'b1) begin n_fd++; fd_addr = int'(ram_addr); end
    end
  end

  function automatic int count_kind(input int b, input byte k);
    int n = 0;
    for (int i = b; i < ev_k.size(); i++) if (ev_k[i] == k) n++;
    return n;
  endfunction

  // Inputs change just after the falling edge, well away from the rising edge
  task automatic cyc(input logic pf, input logic [7:0] pd, input logic rq, input logic [ADDR_W-1:0] ra);
    pi_flag = pf; pi_data = pd; rd_req = rq; rd_addr = ra;
    @(negedge sys_clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, '0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  // Called just after a rising edge with a read granted
  task automatic async_rst_chk(input string nm);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk({nm, "_data"}, 32'({ram_wdata, rd_data}), 32'h0);
    chk({nm, "_ctrl"}, 32'({ram_addr, ram_wr_en, ram_rd_en, rd_valid, frame_done, pic_ready, ovf}), 32'h0);
    @(negedge sys_clk); #1;
    pi_flag = 0; rd_req = 0;
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  int b, rv0, fd0, errs;
  logic [7:0] px [6];

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i]   = 8'(i * 7 + 3);
      m_mem[i] = 8'(i * 7 + 3);
    end
    ram[100] = 8'h5A; m_mem[100] = 8'h5A;

    repeat (3) @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    cmp_en = 1;

    // Quiet after reset release
    b = ev_k.size(); rv0 = n_rv;
    idle(4);
    chk("quiet_events", 32'(ev_k.size() - b), 32'd0);
    chk("quiet_rvalid", 32'(n_rv - rv0), 32'd0);

    // Read latency
    rv0 = n_rv;
    rd_req = 1; rd_addr = 14'd100;
    @(posedge sys_clk); #1;
    chk("rl_rd_en", 32'(ram_rd_en), 32'd1);
    chk("rl_addr", 32'(ram_addr), 32'd100);
    rd_req = 0;
    @(posedge sys_clk); #1;
    chk("rl_valid_early", 32'(rd_valid), 32'd0);
    @(posedge sys_clk); #1;
    chk("rl_valid", 32'(rd_valid), 32'd1);
    chk("rl_data", 32'(rd_data), 32'h5A);
    @(negedge sys_clk); #1;
    idle(3);
    chk("rl_valid_count", 32'(n_rv - rv0), 32'd1);

    // Asynchronous reset with a read in flight and a pixel buffered
    pi_flag = 1; pi_data = 8'hEE; rd_req = 1; rd_addr = 14'd7;
    @(posedge sys_clk);
    async_rst_chk("rst_async1");

    // Write-only frame plus one
    b = ev_k.size(); fd0 = n_fd;
    for (int i = 0; i <= PIC_SIZE; i++) cyc(1'b1, 8'(i), 1'b0, '0);
    idle(5);
    chk("wo_count", 32'(ev_k.size() - b), 32'(PIC_SIZE + 1));
    errs = 0;
    for (int i = 0; i <= PIC_SIZE && b + i < ev_k.size(); i++)
      if (ev_k[b+i] != "W" || ev_a[b+i] != i % PIC_SIZE || ev_d[b+i] != i % 256) errs++;
    chk("wo_seq_errors", 32'(errs), 32'd0);
    chk("wo_fd_count", 32'(n_fd - fd0), 32'd1);
    chk("wo_fd_addr", 32'(fd_addr), 32'd9603);
    chk("wo_pic_ready", 32'(pic_ready), 32'd1);
    chk("wo_wrap_addr", 32'(ev_a[ev_a.size()-1]), 32'd0);
    chk("wo_wrap_data", 32'(ev_d[ev_d.size()-1]), 32'h84);

    // Priority: three reads then three writes in pixel order
    b = ev_k.size();
    px[0] = 8'h11; px[1] = 8'h22; px[2] = 8'h33;
    for (int i = 0; i < 3; i++) cyc(1'b1, px[i], 1'b1, ADDR_W'(200 + i));
    idle(6);
    chk("pri_events", 32'(ev_k.size() - b), 32'd6);
    errs = 0;
    for (int i = 0; i < 6 && b + i < ev_k.size(); i++) begin
      if (i < 3 && ev_k[b+i] != "R") errs++;
      if (i >= 3 && (ev_k[b+i] != "W" || ev_d[b+i] != int'(px[i-3]))) errs++;
    end
    chk("pri_order_errors", 32'(errs), 32'd0);
    chk("pri_ovf", 32'(ovf), 32'd0);

    // Overflow: reads held, six pushes, last two dropped
    b = ev_k.size();
    for (int i = 0; i < 6; i++) begin
      px[i] = 8'(8'hA0 + i);
      cyc(1'b1, px[i], 1'b1, ADDR_W'(300));
    end
    chk("ovf_set", 32'(ovf), 32'd1);
    idle(8);
    chk("ovf_writes", 32'(count_kind(b, "W")), 32'd4);
    errs = 0;
    for (int i = 6; i < 10 && b + i < ev_k.size(); i++)
      if (ev_d[b+i] != int'(px[i-6])) errs++;
    chk("ovf_data_errors", 32'(errs), 32'd0);
    idle(3);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    do_reset();

    // Full FIFO accepts a push in the cycle it is popped
    b = ev_k.size();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b1, ADDR_W'(400));
    cyc(1'b1, 8'hC4, 1'b0, '0);
    idle(8);
    chk("fpp_ovf", 32'(ovf), 32'd0);
    chk("fpp_writes", 32'(count_kind(b, "W")), 32'd5);
    chk("fpp_last_data", 32'(ev_d[ev_d.size()-1]), 32'hC4);

    // Randomized traffic at several read duty cycles
    for (int seg = 0; seg < 4; seg++) begin
      int duty;
      duty = (seg == 0) ? 0 : (seg == 1) ? 25 : (seg == 2) ? 60 : 95;
      for (int i = 0; i < 750; i++)
        cyc(1'($urandom_range(0, 99) < 70), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 99) < duty), ADDR_W'($urandom_range(0, PIC_SIZE - 1)));
    end

    // Reset mid-operation with a read in flight
    pi_flag = 0; rd_req = 1; rd_addr = 14'd7;
    @(posedge sys_clk);
    async_rst_chk("rst_async2");
    b = ev_k.size(); rv0 = n_rv;
    idle(6);
    chk("rst_no_rvalid", 32'(n_rv - rv0), 32'd0);
    chk("rst_no_events", 32'(ev_k.size() - b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port frame-buffer arbiter for the Sobel display path. Accepts the incoming processed pixel stream (`pi_data`/`pi_flag`), buffers it in a small FIFO, and shares one single-port picture RAM between that writer and the VGA picture reader. The display reader has fixed priority. Writes fill the RAM sequentially and wrap once per frame.

## Interface
Parameters:
- `PIC_SIZE`, 9604 — pixels per frame (98×98 Sobel output); valid write addresses are 0..PIC_SIZE-1.
- `ADDR_W`, 14 — RAM address width; must satisfy 2^ADDR_W ≥ PIC_SIZE.
- `FIFO_DEPTH`, 4 — write-buffer entries (power of two, ≥2).

Ports:
- `sys_clk` in 1 — sole clock.
- `sys_rst_n` in 1 — asynchronous, active-low reset.
- `pi_data` in 8 — incoming pixel.
- `pi_flag` in 1 — `pi_data` valid, single-cycle strobe per pixel.
- `rd_req` in 1 — display read request, one per cycle max.
- `rd_addr` in ADDR_W — display read address (caller guarantees < PIC_SIZE).
- `rd_data` out 8 — returned pixel.
- `rd_valid` out 1 — `rd_data` valid, one-cycle pulse per request.
- `ram_addr` out ADDR_W — RAM address.
- `ram_wr_en` out 1 — RAM write strobe.
- `ram_rd_en` out 1 — RAM read strobe.
- `ram_wdata` out 8 — RAM write data.
- `ram_rdata` in 8 — RAM read data, valid 1 cycle after `ram_rd_en`.
- `frame_done` out 1 — one-cycle pulse when the last frame address is written.
- `pic_ready` out 1 — high once at least one full frame has been written.
- `ovf` out 1 — sticky: a pixel was dropped.

## Operation
- **FIFO:** `pi_flag`=1 pushes `pi_data`. A push while full with no pop that cycle drops the pixel and sets `ovf`. A push while full with a pop in the same cycle is accepted. Simultaneous push/pop when non-full leaves the count unchanged.
- **Grant state (registered):** IDLE, READ, WRITE. Evaluated every cycle:
  - `rd_req`=1 → READ: `ram_addr`←`rd_addr`, `ram_rd_en`←1, `ram_wr_en`←0.
  - else FIFO non-empty → WRITE: pop head; `ram_addr`←`wr_addr`, `ram_wdata`←head, `ram_wr_en`←1.
  - else → IDLE: both strobes 0. `ram_addr` and `ram_wdata` hold their last values.
- Reads always win, so writer starvation is bounded only by `rd_req` duty. With `rd_req` held continuously, the FIFO fills and subsequent pixels are dropped (`ovf`).
- **Write address:** `wr_addr` increments after each WRITE grant and wraps from PIC_SIZE-1 to 0. `frame_done` pulses in the same cycle that `ram_wr_en`=1 with `ram_addr`=PIC_SIZE-1. `pic_ready` sets on that cycle and stays set until reset.
- **Read return:** a READ grant sets a pipeline bit. One cycle later `rd_data`←`ram_rdata` and `rd_valid`←1 (registered).
- Strobes are never both high. No combinational path from inputs to any output.

## Timing
- **Reset values** (asynchronous, immediate): `ram_addr`=0, `ram_wr_en`=0, `ram_rd_en`=0, `ram_wdata`=0, `rd_data`=0, `rd_valid`=0, `frame_done`=0, `pic_ready`=0, `ovf`=0. FIFO is emptied, `wr_addr`=0, state=IDLE.
- **Reset mid-operation:** an in-flight read is discarded (no `rd_valid` after release). Buffered pixels are lost.
- **Read latency:** `rd_req` sampled at edge N → `ram_rd_en`/`ram_addr` valid after N → RAM data at N+1 → `rd_valid`/`rd_data` after edge N+2. Back-to-back requests give back-to-back `rd_valid`, throughput 1/cycle.
- **Write latency:** `pi_flag` at edge N into an empty FIFO with `rd_req`=0 → `ram_wr_en` high after edge N+1.
- **Throughput:** sustained 1 pixel/cycle when `rd_req`=0.
- First cycle after reset release: outputs remain at reset values until the first grant.

## Test plan
- **Reset:** assert `sys_rst_n`=0 asynchronously mid-cycle → all outputs 0 immediately. After release, no `rd_valid` and no strobes without stimulus.
- **Write-only:** stream 9604 pixels, values i mod 256, with `rd_req`=0 → `ram_wr_en` at addresses 0..9603 in order with matching data. `frame_done` pulses exactly once, at address 9603. `pic_ready`=1 afterwards. Pixel 9605 writes address 0.
- **Read latency:** `rd_req`=1 with `rd_addr`=100 for one cycle, RAM model holding 0x5A → `ram_rd_en`=1 with `ram_addr`=100 one cycle later. `rd_valid`=1 with `rd_data`=0x5A two cycles after that; no other `rd_valid`.
- **Priority:** `pi_flag` and `rd_req` both high every cycle for 3 cycles, then `rd_req`=0 → 3 READ grants first, then 3 WRITE grants with the pixels in order. No drop, `ovf`=0.
- **Overflow:** hold `rd_req`=1 and push 6 pixels → first 4 buffered, pixels 5 and 6 dropped, `ovf`=1 (sticky). After `rd_req` falls, exactly 4 writes occur.
- **Full-plus-pop:** fill the FIFO to 4 with `rd_req`=1, then drop `rd_req` in the same cycle as a new `pi_flag` → the pixel is accepted, `ovf` stays 0, and 5 writes occur.
